// File: rtl/apu_init_pkg.sv
// Shared types for the APU request initiator: reorder-buffer slot layout,
// request-register states and the slot-index width helper.
package apu_init_pkg;

    localparam int APU_DATA_W   = 32;
    localparam int APU_RFLAGS_W = 5;
    localparam int APU_TAG_W    = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } req_state_e;

    typedef struct packed {
        logic [APU_DATA_W-1:0]   data;
        logic [APU_RFLAGS_W-1:0] flags;
        logic [APU_TAG_W-1:0]    tag;
        logic                    done;
    } slot_t;

    // Width of a slot index; never less than one bit.
    function automatic int slot_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apu_req_initiator_if.sv
// APU request/response bus. Signal suffixes are from the initiator's view;
// master = initiator, slave = responder.
interface apu_req_initiator_if #(
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5
);
    logic                                apu_req_o;
    logic                                apu_gnt_i;
    logic [ID_WIDTH-1:0]                 apu_ID_o;
    logic [NB_ARGS-1:0][DATA_WIDTH-1:0]  apu_operands_o;
    logic [OPCODE_WIDTH-1:0]             apu_op_o;
    logic [FLAGS_IN_WIDTH-1:0]           apu_flags_o;
    logic                                apu_rready_o;
    logic                                apu_rvalid_i;
    logic [DATA_WIDTH-1:0]               apu_rdata_i;
    logic [FLAGS_OUT_WIDTH-1:0]          apu_rflags_i;
    logic [ID_WIDTH-1:0]                 apu_rID_i;

    modport master (
        output apu_req_o, apu_ID_o, apu_operands_o, apu_op_o, apu_flags_o, apu_rready_o,
        input  apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i, apu_rID_i
    );

    modport slave (
        input  apu_req_o, apu_ID_o, apu_operands_o, apu_op_o, apu_flags_o, apu_rready_o,
        output apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i, apu_rID_i
    );
endinterface

// File: rtl/apu_init_rob.sv
// DEPTH-entry reorder buffer. Slots are reserved in command order, filled
// out of order by response ID and retired in order. A response is accepted
// only into an occupied, not-yet-done slot; anything else is flagged.
module apu_init_rob
    import apu_init_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 9
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  alloc_i,
    input  logic [APU_TAG_W-1:0]                  alloc_tag_i,
    output logic [slot_bits(DEPTH)-1:0]           alloc_ptr_o,
    output logic [slot_bits(DEPTH):0]             count_o,
    output logic                                  full_o,
    input  logic                                  cap_valid_i,
    input  logic [ID_WIDTH-1:0]                   cap_id_i,
    input  logic [APU_DATA_W-1:0]                 cap_data_i,
    input  logic [APU_RFLAGS_W-1:0]               cap_flags_i,
    output logic                                  cap_err_o,
    output logic                                  res_valid_o,
    input  logic                                  res_ready_i,
    output logic [APU_DATA_W-1:0]                 res_data_o,
    output logic [APU_RFLAGS_W-1:0]               res_flags_o,
    output logic [APU_TAG_W-1:0]                  res_tag_o
);
    localparam int             SB       = slot_bits(DEPTH);
    localparam logic [SB:0]    FULL_CNT = (SB+1)'(DEPTH);
    localparam logic [SB:0]    CNT_ONE  = (SB+1)'(1);
    localparam logic [SB-1:0]  PTR_ONE  = SB'(1);

    slot_t          slot_q [DEPTH];
    logic [SB-1:0]  alloc_ptr_q;
    logic [SB-1:0]  retire_ptr_q;
    logic [SB:0]    count_q;

    logic [SB-1:0]  cap_idx;
    logic [SB-1:0]  cap_off;
    logic           id_hi_zero;
    logic           cap_ok;
    logic           retire;

    assign cap_idx = cap_id_i[SB-1:0];
    assign cap_off = cap_idx - retire_ptr_q;

    if (ID_WIDTH > SB) begin : g_id_hi
        assign id_hi_zero = (cap_id_i[ID_WIDTH-1:SB] == '0);
    end else begin : g_id_no_hi
        assign id_hi_zero = 1'b1;
    end

    // Slot X retiring this cycle is done, so a response to it fails the done test.
    assign cap_ok    = cap_valid_i && id_hi_zero && ({1'b0, cap_off} < count_q)
                       && !slot_q[cap_idx].done;
    assign cap_err_o = cap_valid_i && !cap_ok;

    assign res_valid_o = (count_q != '0) && slot_q[retire_ptr_q].done;
    assign res_data_o  = slot_q[retire_ptr_q].data;
    assign res_flags_o = slot_q[retire_ptr_q].flags;
    assign res_tag_o   = slot_q[retire_ptr_q].tag;
    assign retire      = res_valid_o && res_ready_i;

    assign alloc_ptr_o = alloc_ptr_q;
    assign count_o     = count_q;
    assign full_o      = (count_q == FULL_CNT);

    // Per-slot storage: tag on allocation, result on capture, done cleared on retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_i && (alloc_ptr_q == SB'(i))) begin
                    slot_q[i].tag  <= alloc_tag_i;
                    slot_q[i].done <= 1'b0;
                end
                if (cap_ok && (cap_idx == SB'(i))) begin
                    slot_q[i].data  <= cap_data_i;
                    slot_q[i].flags <= cap_flags_i;
                    slot_q[i].done  <= 1'b1;
                end
                if (retire && (retire_ptr_q == SB'(i))) begin
                    slot_q[i].done <= 1'b0;
                end
            end
        end
    end

    // Pointers wrap modulo DEPTH; simultaneous alloc and retire leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_q  <= '0;
            retire_ptr_q <= '0;
            count_q      <= '0;
        end else begin
            if (alloc_i) begin
                alloc_ptr_q <= alloc_ptr_q + PTR_ONE;
            end
            if (retire) begin
                retire_ptr_q <= retire_ptr_q + PTR_ONE;
            end
            case ({alloc_i, retire})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/apu_req_initiator.sv
// APU request initiator: accepts commands, reserves a reorder slot, issues the
// request with the slot index as ID, and retires results in command order.
// Optional watchdog: define APU_REQ_INITIATOR_TIMEOUT_EN to add timeout_o.
//
// state | meaning
// IDLE  | no request on the bus
// REQ   | apu_req_o high, ID and payload held until apu_gnt_i
module apu_req_initiator
    import apu_init_pkg::*;
#(
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 2,
    parameter int DATA_WIDTH      = APU_DATA_W,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = APU_RFLAGS_W,
    parameter int TAG_WIDTH       = APU_TAG_W,
    parameter int DEPTH           = 4
`ifdef APU_REQ_INITIATOR_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 1024
`endif
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cmd_valid_i,
    output logic                                cmd_ready_o,
    input  logic [NB_ARGS-1:0][DATA_WIDTH-1:0]  cmd_operands_i,
    input  logic [OPCODE_WIDTH-1:0]             cmd_op_i,
    input  logic [FLAGS_IN_WIDTH-1:0]           cmd_flags_i,
    input  logic [TAG_WIDTH-1:0]                cmd_tag_i,
    apu_req_initiator_if.master                 apu,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output logic [DATA_WIDTH-1:0]               res_data_o,
    output logic [FLAGS_OUT_WIDTH-1:0]          res_flags_o,
    output logic [TAG_WIDTH-1:0]                res_tag_o,
    output logic                                busy_o,
    output logic                                err_o
`ifdef APU_REQ_INITIATOR_TIMEOUT_EN
    ,
    output logic                                timeout_o
`endif
);
    localparam int SB = slot_bits(DEPTH);

    req_state_e                          state_q, state_d;
    logic [ID_WIDTH-1:0]                 id_q;
    logic [NB_ARGS-1:0][DATA_WIDTH-1:0]  operands_q;
    logic [OPCODE_WIDTH-1:0]             op_q;
    logic [FLAGS_IN_WIDTH-1:0]           flags_q;
    logic                                err_q;

    logic           accept;
    logic           full;
    logic           cap_err;
    logic           tmo_fire;
    logic [SB-1:0]  alloc_ptr;
    logic [SB:0]    count;

    // The reserved slot counts as occupied while its request is still pending.
    assign cmd_ready_o = ((state_q == IDLE) || apu.apu_gnt_i) && !full;
    assign accept      = cmd_valid_i && cmd_ready_o;

    // Next request-register state; a grant with a new accept stays in REQ.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (apu.apu_gnt_i && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload and ID captured on every accept, held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q       <= '0;
            operands_q <= '0;
            op_q       <= '0;
            flags_q    <= '0;
        end else if (accept) begin
            id_q       <= ID_WIDTH'(alloc_ptr);
            operands_q <= cmd_operands_i;
            op_q       <= cmd_op_i;
            flags_q    <= cmd_flags_i;
        end
    end

    assign apu.apu_req_o      = (state_q == REQ);
    assign apu.apu_ID_o       = id_q;
    assign apu.apu_operands_o = operands_q;
    assign apu.apu_op_o       = op_q;
    assign apu.apu_flags_o    = flags_q;
    assign apu.apu_rready_o   = 1'b1;

    apu_init_rob #(
        .DEPTH    (DEPTH),
        .ID_WIDTH (ID_WIDTH)
    ) u_rob (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_i     (accept),
        .alloc_tag_i (cmd_tag_i),
        .alloc_ptr_o (alloc_ptr),
        .count_o     (count),
        .full_o      (full),
        .cap_valid_i (apu.apu_rvalid_i),
        .cap_id_i    (apu.apu_rID_i),
        .cap_data_i  (apu.apu_rdata_i),
        .cap_flags_i (apu.apu_rflags_i),
        .cap_err_o   (cap_err),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .res_flags_o (res_flags_o),
        .res_tag_o   (res_tag_o)
    );

    assign busy_o = (count != '0) || apu.apu_req_o;

`ifdef APU_REQ_INITIATOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0]  tmr_q;
    logic           tmo_q;
    logic           waiting;

    assign waiting   = (count != '0) && !res_valid_o;
    assign tmo_fire  = waiting && (tmr_q == TW'(1));
    assign timeout_o = tmo_q;

    // Watchdog down-counter: reloads whenever the oldest op is not outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= TW'(TIMEOUT_CYCLES);
            tmo_q <= 1'b0;
        end else begin
            if (!waiting) begin
                tmr_q <= TW'(TIMEOUT_CYCLES);
            end else if (tmr_q != '0) begin
                tmr_q <= tmr_q - TW'(1);
            end
            if (tmo_fire) begin
                tmo_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Sticky error: dropped response or watchdog expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (cap_err || tmo_fire) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_apu_req_initiator.sv
// Directed self-checking bench for apu_req_initiator.
module tb_apu_req_initiator;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0][31:0]    cmd_operands;
    logic [5:0]          cmd_op;
    logic [14:0]         cmd_flags;
    logic [4:0]          cmd_tag;
    logic                res_valid;
    logic                res_ready;
    logic [31:0]         res_data;
    logic [4:0]          res_flags;
    logic [4:0]          res_tag;
    logic                busy;
    logic                err;
`ifdef APU_REQ_INITIATOR_TIMEOUT_EN
    logic                timeout;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apu_req_initiator_if #(
        .ID_WIDTH(9), .NB_ARGS(2), .DATA_WIDTH(32),
        .OPCODE_WIDTH(6), .FLAGS_IN_WIDTH(15), .FLAGS_OUT_WIDTH(5)
    ) apu ();

    apu_req_initiator #(
        .ID_WIDTH(9), .NB_ARGS(2), .DATA_WIDTH(32), .OPCODE_WIDTH(6),
        .FLAGS_IN_WIDTH(15), .FLAGS_OUT_WIDTH(5), .TAG_WIDTH(5), .DEPTH(4)
`ifdef APU_REQ_INITIATOR_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_operands_i (cmd_operands),
        .cmd_op_i       (cmd_op),
        .cmd_flags_i    (cmd_flags),
        .cmd_tag_i      (cmd_tag),
        .apu            (apu.master),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_data_o     (res_data),
        .res_flags_o    (res_flags),
        .res_tag_o      (res_tag),
        .busy_o         (busy),
        .err_o          (err)
`ifdef APU_REQ_INITIATOR_TIMEOUT_EN
        , .timeout_o    (timeout)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic quiet_bus();
        cmd_valid        = 1'b0;
        apu.apu_gnt_i    = 1'b0;
        apu.apu_rvalid_i = 1'b0;
        apu.apu_rID_i    = '0;
        apu.apu_rdata_i  = '0;
        apu.apu_rflags_i = '0;
    endtask

    task automatic set_cmd(input logic [4:0] tag, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [14:0] flags);
        cmd_valid       = 1'b1;
        cmd_tag         = tag;
        cmd_op          = op;
        cmd_operands[0] = a;
        cmd_operands[1] = b;
        cmd_flags       = flags;
    endtask

    task automatic rsp(input logic [8:0] id, input logic [31:0] data, input logic [4:0] flags);
        apu.apu_rvalid_i = 1'b1;
        apu.apu_rID_i    = id;
        apu.apu_rdata_i  = data;
        apu.apu_rflags_i = flags;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int  ord [4];
        int  sent, granted, retired;
        bit  acc, gev, rev;

        rst_n = 1'b0;
        quiet_bus();
        res_ready    = 1'b0;
        cmd_operands = '0;
        cmd_op       = '0;
        cmd_flags    = '0;
        cmd_tag      = '0;
        tick();
        tick();

        // Reset values
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rready",    64'(apu.apu_rready_o), 64'd1);
        chk("rst_req",       64'(apu.apu_req_o), 64'd0);
        chk("rst_id",        64'(apu.apu_ID_o), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_tag",   64'(res_tag), 64'd0);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_err",       64'(err), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single op, responder latency 2
        set_cmd(5'd3, 6'h02, 32'h5, 32'h7, 15'h0003);
        settle();
        chk("t1_ready", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        settle();
        chk("t1_req",       64'(apu.apu_req_o), 64'd1);
        chk("t1_id",        64'(apu.apu_ID_o), 64'd0);
        chk("t1_op",        64'(apu.apu_op_o), 64'h02);
        chk("t1_operands",  64'(apu.apu_operands_o), 64'h0000_0007_0000_0005);
        chk("t1_flags",     64'(apu.apu_flags_o), 64'h0003);
        chk("t1_busy",      64'(busy), 64'd1);
        chk("t1_ready_req", 64'(cmd_ready), 64'd0);
        apu.apu_gnt_i = 1'b1;
        settle();
        chk("t1_ready_gnt", 64'(cmd_ready), 64'd1);
        tick();
        apu.apu_gnt_i = 1'b0;
        settle();
        chk("t1_req_drop", 64'(apu.apu_req_o), 64'd0);
        tick();
        rsp(9'd0, 32'd12, 5'h01);
        settle();
        chk("t1_res_before", 64'(res_valid), 64'd0);
        tick();
        quiet_bus();
        settle();
        chk("t1_res_valid", 64'(res_valid), 64'd1);
        chk("t1_res_tag",   64'(res_tag), 64'd3);
        chk("t1_res_data",  64'(res_data), 64'd12);
        chk("t1_res_flags", 64'(res_flags), 64'h01);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        settle();
        chk("t1_res_gone", 64'(res_valid), 64'd0);
        chk("t1_idle",     64'(busy), 64'd0);
        chk("t1_err",      64'(err), 64'd0);

        pulse_reset();

        // Out-of-order return into a full buffer
        apu.apu_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(5'(10 + i), 6'h01, 32'(i), 32'h0, 15'h0);
            settle();
            chk("t2_ready", 64'(cmd_ready), 64'd1);
            tick();
            settle();
            chk("t2_id", 64'(apu.apu_ID_o), 64'(i));
        end
        set_cmd(5'd14, 6'h01, 32'h0, 32'h0, 15'h0);
        settle();
        chk("t2_full_block", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b0;
        tick();
        apu.apu_gnt_i = 1'b0;
        settle();
        chk("t2_req_drop",  64'(apu.apu_req_o), 64'd0);
        chk("t2_full_idle", 64'(cmd_ready), 64'd0);
        ord = '{2, 0, 3, 1};
        for (int j = 0; j < 4; j++) begin
            rsp(9'(ord[j]), 32'hD000_0000 + 32'(ord[j]), 5'(ord[j]));
            tick();
            settle();
            chk("t2_res_valid_fill", 64'(res_valid), (j >= 1) ? 64'd1 : 64'd0);
        end
        quiet_bus();
        chk("t2_err", 64'(err), 64'd0);
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t2_ret_valid", 64'(res_valid), 64'd1);
            chk("t2_ret_tag",   64'(res_tag), 64'(10 + k));
            chk("t2_ret_data",  64'(res_data), 64'hD000_0000 + 64'(k));
            chk("t2_ret_ready", 64'(cmd_ready), (k >= 1) ? 64'd1 : 64'd0);
            tick();
        end
        res_ready = 1'b0;
        settle();
        chk("t2_empty", 64'(res_valid), 64'd0);
        chk("t2_busy",  64'(busy), 64'd0);

        // Grant stall for 5 cycles
        set_cmd(5'd7, 6'h05, 32'h1111, 32'h2222, 15'h1234);
        tick();
        cmd_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            settle();
            chk("t3_req",   64'(apu.apu_req_o), 64'd1);
            chk("t3_ops",   64'(apu.apu_operands_o), 64'h0000_2222_0000_1111);
            chk("t3_ctl",   64'({apu.apu_ID_o, apu.apu_op_o, apu.apu_flags_o}),
                            64'({9'd0, 6'h05, 15'h1234}));
            chk("t3_ready", 64'(cmd_ready), 64'd0);
            tick();
        end
        apu.apu_gnt_i = 1'b1;
        tick();
        apu.apu_gnt_i = 1'b0;
        settle();
        chk("t3_req_drop", 64'(apu.apu_req_o), 64'd0);
        rsp(9'd0, 32'h3333, 5'h0);
        tick();
        quiet_bus();
        settle();
        chk("t3_res_tag",  64'(res_tag), 64'd7);
        chk("t3_res_data", 64'(res_data), 64'h3333);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Backpressure with 4 done slots, then stream 12 more with wrap
        sent = 0;
        granted = 0;
        retired = 0;
        for (int c = 0; c < 40 && granted < 4; c++) begin
            cmd_valid        = (sent < 4);
            cmd_tag          = 5'(sent);
            cmd_operands[0]  = 32'(sent);
            cmd_operands[1]  = ~32'(sent);
            apu.apu_gnt_i    = 1'b1;
            apu.apu_rvalid_i = apu.apu_req_o;
            apu.apu_rID_i    = apu.apu_ID_o;
            apu.apu_rdata_i  = 32'hC000_0000 + 32'(granted);
            apu.apu_rflags_i = 5'(granted);
            settle();
            if (apu.apu_req_o) chk("t4_issue_op", 64'(apu.apu_operands_o[0]), 64'(granted));
            acc = cmd_valid && cmd_ready;
            gev = apu.apu_req_o && apu.apu_gnt_i;
            tick();
            if (acc) sent++;
            if (gev) granted++;
        end
        chk("t4_fill_granted", 64'(granted), 64'd4);
        quiet_bus();
        set_cmd(5'(sent), 6'h01, 32'(sent), ~32'(sent), 15'h0);
        settle();
        chk("t4_full_ready", 64'(cmd_ready), 64'd0);
        chk("t4_held_valid", 64'(res_valid), 64'd1);
        chk("t4_held_tag",   64'(res_tag), 64'd0);
        res_ready = 1'b1;
        for (int c = 0; c < 120 && retired < 16; c++) begin
            cmd_valid        = (sent < 16);
            cmd_tag          = 5'(sent);
            cmd_operands[0]  = 32'(sent);
            cmd_operands[1]  = ~32'(sent);
            apu.apu_gnt_i    = 1'b1;
            apu.apu_rvalid_i = apu.apu_req_o;
            apu.apu_rID_i    = apu.apu_ID_o;
            apu.apu_rdata_i  = 32'hC000_0000 + 32'(granted);
            apu.apu_rflags_i = 5'(granted);
            settle();
            if (apu.apu_req_o) chk("t4_issue_op", 64'(apu.apu_operands_o[0]), 64'(granted));
            acc = cmd_valid && cmd_ready;
            gev = apu.apu_req_o && apu.apu_gnt_i;
            rev = res_valid && res_ready;
            if (rev) begin
                chk("t4_ret_tag",   64'(res_tag), 64'(retired % 32));
                chk("t4_ret_data",  64'(res_data), 64'hC000_0000 + 64'(retired));
                chk("t4_ret_flags", 64'(res_flags), 64'(retired % 32));
            end
            tick();
            if (acc) sent++;
            if (gev) granted++;
            if (rev) retired++;
        end
        quiet_bus();
        res_ready = 1'b0;
        chk("t4_all_retired", 64'(retired), 64'd16);
        settle();
        chk("t4_err",  64'(err), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);

        // Reset mid-flight, then a stale response
        pulse_reset();
        set_cmd(5'd1, 6'h01, 32'h1, 32'h2, 15'h0);
        tick();
        cmd_valid = 1'b0;
        apu.apu_gnt_i = 1'b1;
        tick();
        apu.apu_gnt_i = 1'b0;
        rst_n = 1'b0;
        settle();
        chk("t5_rst_busy",  64'(busy), 64'd0);
        chk("t5_rst_req",   64'(apu.apu_req_o), 64'd0);
        chk("t5_rst_ready", 64'(cmd_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        rsp(9'd0, 32'hDEAD, 5'h0);
        tick();
        quiet_bus();
        settle();
        chk("t5_stale_err",   64'(err), 64'd1);
        chk("t5_stale_valid", 64'(res_valid), 64'd0);

        // Bad ID and duplicate response
        pulse_reset();
        settle();
        chk("t6_err_clear", 64'(err), 64'd0);
        set_cmd(5'd21, 6'h01, 32'h10, 32'h20, 15'h0);
        tick();
        cmd_valid = 1'b0;
        apu.apu_gnt_i = 1'b1;
        tick();
        apu.apu_gnt_i = 1'b0;
        rsp(9'h100, 32'hBAD0, 5'h1f);
        tick();
        settle();
        chk("t6_badid_err",   64'(err), 64'd1);
        chk("t6_badid_valid", 64'(res_valid), 64'd0);
        rsp(9'd0, 32'h600D, 5'h02);
        tick();
        settle();
        chk("t6_good_valid", 64'(res_valid), 64'd1);
        chk("t6_good_data",  64'(res_data), 64'h600D);
        rsp(9'd0, 32'hBAD1, 5'h03);
        tick();
        quiet_bus();
        settle();
        chk("t6_dup_data",  64'(res_data), 64'h600D);
        chk("t6_dup_flags", 64'(res_flags), 64'h02);
        chk("t6_dup_tag",   64'(res_tag), 64'd21);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        set_cmd(5'd22, 6'h01, 32'h30, 32'h40, 15'h0);
        tick();
        cmd_valid = 1'b0;
        settle();
        chk("t6_next_id", 64'(apu.apu_ID_o), 64'd1);
        apu.apu_gnt_i = 1'b1;
        tick();
        apu.apu_gnt_i = 1'b0;
        rsp(9'd1, 32'h77, 5'h0);
        tick();
        quiet_bus();
        settle();
        chk("t6_next_tag",  64'(res_tag), 64'd22);
        chk("t6_next_data", 64'(res_data), 64'h77);
        chk("t6_sticky",    64'(err), 64'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

`ifdef APU_REQ_INITIATOR_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYCLES=16
        pulse_reset();
        set_cmd(5'd9, 6'h01, 32'h1, 32'h1, 15'h0);
        tick();
        cmd_valid = 1'b0;
        apu.apu_gnt_i = 1'b1;
        tick();
        apu.apu_gnt_i = 1'b0;
        repeat (14) tick();
        settle();
        chk("t7_tmo_early", 64'(timeout), 64'd0);
        chk("t7_err_early", 64'(err), 64'd0);
        tick();
        settle();
        chk("t7_tmo", 64'(timeout), 64'd1);
        chk("t7_err", 64'(err), 64'd1);
        rst_n = 1'b0;
        settle();
        chk("t7_rst_tmo",  64'(timeout), 64'd0);
        chk("t7_rst_err",  64'(err), 64'd0);
        chk("t7_rst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apu_req_initiator.md
Name: apu_req_initiator

Overview:
- Initiator (master) end of the APU request/response protocol; drives an FPnew-based APU responder from a core or accelerator front end.
- Accepts commands, allocates one of DEPTH outstanding slots, and issues the request with the slot index as apu_ID.
- Captures responses, which may return out of order, by apu_rID, then retires results strictly in command order with the caller's tag.
- The responder ignores rready, so every accepted response must land in a pre-reserved slot.

Parameters:
- ID_WIDTH, 9: APU ID width.
- NB_ARGS, 2: operands per request.
- DATA_WIDTH, 32: operand/result width.
- OPCODE_WIDTH, 6: apu_op width.
- FLAGS_IN_WIDTH, 15: apu_flags width.
- FLAGS_OUT_WIDTH, 5: apu_rflags width.
- TAG_WIDTH, 5: caller destination tag width.
- DEPTH, 4: max outstanding ops; power of 2, 2..2^ID_WIDTH.
- TIMEOUT_CYCLES, 1024: watchdog limit (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_operands_i  in  NB_ARGS x DATA_WIDTH  operands
- cmd_op_i  in  OPCODE_WIDTH  opcode
- cmd_flags_i  in  FLAGS_IN_WIDTH  format/rounding flags
- cmd_tag_i  in  TAG_WIDTH  caller tag, returned with result
- apu_req_o  out  1  request valid
- apu_gnt_i  in  1  request grant
- apu_ID_o  out  ID_WIDTH  zero-extended slot index
- apu_operands_o  out  NB_ARGS x DATA_WIDTH  registered operands
- apu_op_o  out  OPCODE_WIDTH  registered opcode
- apu_flags_o  out  FLAGS_IN_WIDTH  registered flags
- apu_rready_o  out  1  constant 1
- apu_rvalid_i  in  1  response valid
- apu_rdata_i  in  DATA_WIDTH  result
- apu_rflags_i  in  FLAGS_OUT_WIDTH  status flags
- apu_rID_i  in  ID_WIDTH  response ID
- res_valid_o  out  1  in-order result valid
- res_ready_i  in  1  result consumed
- res_data_o  out  DATA_WIDTH  result data
- res_flags_o  out  FLAGS_OUT_WIDTH  result flags
- res_tag_o  out  TAG_WIDTH  caller tag
- busy_o  out  1  count!=0 or apu_req_o
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. All state clears. All outputs are 0 except apu_rready_o=1 and cmd_ready_o=1. Reset mid-operation discards every in-flight op; later responses carrying stale IDs then set err_o.
- State: alloc_ptr, retire_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), per-slot done bit, data, flags and tag.
- Request register: two states, IDLE and REQ.
  - cmd accept: tag is written to slot[alloc_ptr], payload is registered, alloc_ptr++, count++, go to REQ. apu_req_o rises the next cycle.
  - In REQ, apu_req_o, ID and payload hold stable until apu_gnt_i.
  - On gnt with no new cmd accepted in the same cycle: go to IDLE. A simultaneous cmd accept stays in REQ, giving back-to-back issue at one op per cycle.
- cmd_ready_o = (IDLE or apu_gnt_i) and count<DEPTH. count includes the slot reserved by a pending request, so a full buffer blocks the command.
- Response capture: on apu_rvalid_i, rID is valid when its upper bits are 0, the slot is occupied (within count from retire_ptr) and done=0.
  - Valid ID: store data/flags, set done.
  - Otherwise: drop the response and set err_o (sticky until reset).
- Retire: res_valid_o = count>0 and done[retire_ptr]. res_* come combinationally from slot[retire_ptr]. On valid&ready: clear done, retire_ptr++, count--.
- Latency: minimum cmd→res is 1 (req) + responder latency + 1 (capture register).
- Simultaneous alloc and retire: count unchanged. A response to slot X in the same cycle X retires is impossible by construction; it is treated as an error.
- A response arriving in the same cycle as its grant is legal (0-latency responder).
- Full: cmd_ready_o=0 until a retire. Empty: res_valid_o=0.

Optional Feature:
- Macro: APU_REQ_INITIATOR_TIMEOUT_EN.
- Defined: a counter runs while count>0 and done[retire_ptr]=0, and resets on each retire. Reaching TIMEOUT_CYCLES sets err_o and a sticky timeout_o output port.
- Undefined: no counter and no timeout_o port; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package apu_init_pkg holds:
  - the slot_t struct {data, flags, tag, done};
  - the req_state_e enum {IDLE, REQ};
  - the SLOT_BITS = $clog2(DEPTH) helper function.
- One sub-module, apu_init_rob: DEPTH-entry reorder buffer with alloc/capture/retire ports, pointers and count.

Test Plan:
- Single op: cmd tag=3, op=ADD, responder latency 2 → apu_ID_o=0. res_valid_o, res_tag_o=3 and result appear 1 cycle after rvalid.
- Out-of-order return: 4 cmds tags 10..13, responses rID 2,0,3,1 → results retire in tag order 10,11,12,13. cmd_ready_o=0 after the 4th accept until the first retire.
- Grant stall: hold apu_gnt_i=0 for 5 cycles → apu_req_o and payload stable for 5 cycles. One op is issued on gnt.
- Backpressure plus wrap: res_ready_i=0 with 4 done slots, then stream 12 ops → pointers wrap 3 times and no data is lost or reordered.
- Bad ID: rID=9'h100, then a duplicate rID=0 after done → both dropped. err_o=1 sticky, good results unaffected.
- Timeout (macro on, TIMEOUT_CYCLES=16): no response for 16 cycles → timeout_o=1, err_o=1. Reset mid-flight clears all outputs.
